// File: rtl/ddr_burst_reader_if.sv
// AXI4 read-address/read-data channels plus the outgoing AXI4-Stream for ddr_burst_reader.
// The master modport is the reader; the slave modport is the memory/sink side.
interface ddr_burst_reader_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64
);
  logic [ADDR_WIDTH-1:0] m_axi_araddr;
  logic [7:0]            m_axi_arlen;
  logic [2:0]            m_axi_arsize;
  logic [1:0]            m_axi_arburst;
  logic                  m_axi_arvalid;
  logic                  m_axi_arready;
  logic [DATA_WIDTH-1:0] m_axi_rdata;
  logic [1:0]            m_axi_rresp;
  logic                  m_axi_rlast;
  logic                  m_axi_rvalid;
  logic                  m_axi_rready;
  logic [DATA_WIDTH-1:0] m_axis_tdata;
  logic                  m_axis_tvalid;
  logic                  m_axis_tready;
  logic                  m_axis_tlast;

  modport master (
    output m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid,
    input  m_axi_arready,
    input  m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
    output m_axi_rready,
    output m_axis_tdata, m_axis_tvalid, m_axis_tlast,
    input  m_axis_tready
  );

  modport slave (
    input  m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid,
    output m_axi_arready,
    output m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
    input  m_axi_rready,
    input  m_axis_tdata, m_axis_tvalid, m_axis_tlast,
    output m_axis_tready
  );
endinterface

// File: rtl/ddr_burst_reader.sv
// AXI4 read master streaming a contiguous DDR region into a 64-bit AXI4-Stream through a
// 2-entry skid FIFO, with sticky response-error flag and active-cycle counter.
module ddr_burst_reader #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 32,
  parameter int BURST_LEN  = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [15:0]           n_bursts,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [31:0]           cycles,
  ddr_burst_reader_if.master    bus
);
  localparam int BL_W  = $clog2(BURST_LEN);
  localparam int TOT_W = 16 + BL_W;
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACTIVE = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;
  localparam logic [ADDR_WIDTH-1:0] BURST_BYTES = ADDR_WIDTH'(BURST_LEN * 8);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK  = ~ADDR_WIDTH'(BURST_LEN * 8 - 1);
  localparam logic [BL_W-1:0]       LAST_IDX    = BL_W'(BURST_LEN - 1);

  logic [1:0]            state_q, state_d;
  logic [15:0]           nb_q, nb_d;
  logic [TOT_W-1:0]      total_q, total_d;
  logic [TOT_W-1:0]      beats_out_q, beats_out_d;
  logic [15:0]           ar_sent_q, ar_sent_d;
  logic [1:0]            out_q, out_d;
  logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic                  arvalid_q, arvalid_d;
  logic [BL_W-1:0]       beat_q, beat_d;
  logic                  err_q, err_d;
  logic [31:0]           cycles_q, cycles_d;
  logic                  zero_run_q, zero_run_d;
  logic [DATA_WIDTH-1:0] mem_q [2];
  logic                  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [1:0]            cnt_q, cnt_d;

  logic ar_hs_s, r_hs_s, ax_hs_s, rready_s, tvalid_s, last_s, burst_end_s, beat_bad_s;

  assign rready_s    = (state_q == S_ACTIVE) && (cnt_q < 2'd2);
  assign tvalid_s    = (state_q == S_ACTIVE) && (cnt_q != 2'd0);
  assign last_s      = tvalid_s && (beats_out_q == (total_q - TOT_W'(1)));
  assign ar_hs_s     = arvalid_q && bus.m_axi_arready;
  assign r_hs_s      = bus.m_axi_rvalid && rready_s;
  assign ax_hs_s     = tvalid_s && bus.m_axis_tready;
  assign burst_end_s = r_hs_s && bus.m_axi_rlast;
  assign beat_bad_s  = (bus.m_axi_rresp != 2'b00) || (bus.m_axi_rlast != (beat_q == LAST_IDX));

  // Control FSM, AR issue, outstanding-burst tracking and status counters
  always_comb begin
    state_d     = state_q;
    nb_d        = nb_q;
    total_d     = total_q;
    beats_out_d = beats_out_q;
    ar_sent_d   = ar_sent_q;
    out_d       = out_q;
    araddr_d    = araddr_q;
    arvalid_d   = arvalid_q;
    beat_d      = beat_q;
    err_d       = err_q;
    cycles_d    = cycles_q;
    zero_run_d  = zero_run_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          araddr_d    = base_addr & ALIGN_MASK;
          nb_d        = n_bursts;
          total_d     = {n_bursts, {BL_W{1'b0}}};
          beats_out_d = '0;
          ar_sent_d   = 16'd0;
          out_d       = 2'd0;
          beat_d      = '0;
          err_d       = 1'b0;
          cycles_d    = 32'd0;
          arvalid_d   = (n_bursts != 16'd0);
          zero_run_d  = (n_bursts == 16'd0);
          state_d     = (n_bursts != 16'd0) ? S_ACTIVE : S_DONE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ACTIVE: begin
        cycles_d = cycles_q + 32'd1;
        if (ar_hs_s) begin
          ar_sent_d = ar_sent_q + 16'd1;
          araddr_d  = araddr_q + BURST_BYTES;
        end else begin
          ar_sent_d = ar_sent_q;
          araddr_d  = araddr_q;
        end
        if (ar_hs_s && !burst_end_s) begin
          out_d = out_q + 2'd1;
        end else if (!ar_hs_s && burst_end_s && (out_q != 2'd0)) begin
          out_d = out_q - 2'd1;
        end else begin
          out_d = out_q;
        end
        // A pending request keeps its address until the slave takes it
        if (arvalid_q && !bus.m_axi_arready) begin
          arvalid_d = 1'b1;
        end else begin
          arvalid_d = (ar_sent_d < nb_q) && (out_d < 2'd2);
        end
        if (r_hs_s) begin
          beat_d = beat_q + BL_W'(1);
          err_d  = err_q | beat_bad_s;
        end else begin
          beat_d = beat_q;
          err_d  = err_q;
        end
        if (ax_hs_s) begin
          beats_out_d = beats_out_q + TOT_W'(1);
          state_d     = last_s ? S_DONE : S_ACTIVE;
        end else begin
          beats_out_d = beats_out_q;
          state_d     = S_ACTIVE;
        end
      end
      S_DONE: begin
        // A zero-length run lingers one extra cycle before pulsing done
        zero_run_d = 1'b0;
        arvalid_d  = 1'b0;
        state_d    = zero_run_q ? S_DONE : S_IDLE;
      end
      default: begin
        state_d   = S_IDLE;
        arvalid_d = 1'b0;
      end
    endcase
  end

  // Skid FIFO occupancy and pointers
  always_comb begin
    if (r_hs_s && !ax_hs_s) begin
      cnt_d = cnt_q + 2'd1;
    end else if (!r_hs_s && ax_hs_s) begin
      cnt_d = cnt_q - 2'd1;
    end else begin
      cnt_d = cnt_q;
    end
    wptr_d = r_hs_s ? ~wptr_q : wptr_q;
    rptr_d = ax_hs_s ? ~rptr_q : rptr_q;
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      nb_q        <= 16'd0;
      total_q     <= '0;
      beats_out_q <= '0;
      ar_sent_q   <= 16'd0;
      out_q       <= 2'd0;
      araddr_q    <= '0;
      arvalid_q   <= 1'b0;
      beat_q      <= '0;
      err_q       <= 1'b0;
      cycles_q    <= 32'd0;
      zero_run_q  <= 1'b0;
      mem_q[0]    <= '0;
      mem_q[1]    <= '0;
      wptr_q      <= 1'b0;
      rptr_q      <= 1'b0;
      cnt_q       <= 2'd0;
    end else begin
      state_q     <= state_d;
      nb_q        <= nb_d;
      total_q     <= total_d;
      beats_out_q <= beats_out_d;
      ar_sent_q   <= ar_sent_d;
      out_q       <= out_d;
      araddr_q    <= araddr_d;
      arvalid_q   <= arvalid_d;
      beat_q      <= beat_d;
      err_q       <= err_d;
      cycles_q    <= cycles_d;
      zero_run_q  <= zero_run_d;
      if (r_hs_s) begin
        mem_q[wptr_q] <= bus.m_axi_rdata;
      end else begin
        mem_q[wptr_q] <= mem_q[wptr_q];
      end
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.m_axi_araddr  = araddr_q;
  assign bus.m_axi_arlen   = 8'(BURST_LEN - 1);
  assign bus.m_axi_arsize  = 3'd3;
  assign bus.m_axi_arburst = 2'b01;
  assign bus.m_axi_arvalid = arvalid_q;
  assign bus.m_axi_rready  = rready_s;
  assign bus.m_axis_tdata  = mem_q[rptr_q];
  assign bus.m_axis_tvalid = tvalid_s;
  assign bus.m_axis_tlast  = last_s;

  assign busy   = (state_q != S_IDLE);
  assign done   = (state_q == S_DONE) && !zero_run_q;
  assign err    = err_q;
  assign cycles = cycles_q;
endmodule

// File: tb/tb_ddr_burst_reader.sv
// Directed bench for ddr_burst_reader: table of full transfers plus hand-written sequences
// for response faults, zero-length runs and reset in mid-transfer.
module tb_ddr_burst_reader;
  localparam int BL = 16;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start;
  logic [31:0] base_addr;
  logic [15:0] n_bursts;
  logic        busy, done, err;
  logic [31:0] cycles;

  ddr_burst_reader_if #(.ADDR_WIDTH(32), .DATA_WIDTH(64)) bus ();

  ddr_burst_reader #(.DATA_WIDTH(64), .ADDR_WIDTH(32), .BURST_LEN(BL)) dut (
    .clk(clk), .rstn(rstn), .start(start), .base_addr(base_addr), .n_bursts(n_bursts),
    .busy(busy), .done(done), .err(err), .cycles(cycles), .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] base;
    logic [15:0] nb;
    int          tr_mode;
    int          rgap;
    logic [31:0] addr0;
    int          beats;
    int          exp_cycles;
  } vec_t;

  vec_t vecs [4];
  int pass_cnt = 0;
  int total_cnt = 0;

  int tr_mode = 0, rgap = 0, fault_resp = -1, fault_last = -1;
  logic [31:0] ar_q [$];
  logic [31:0] ar_log [$];
  logic [63:0] rx_q [$];
  logic [7:0]  last_arlen;
  logic [2:0]  last_arsize;
  logic [1:0]  last_arburst;
  int cur_beat = 0, r_count = 0, slv_out = 0, max_out = 0, stab_err = 0, cyc = 0;
  int tlast_cnt = 0, tlast_idx = -1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  function automatic logic [63:0] word_at(input logic [31:0] a);
    return {~a, a};
  endfunction

  // Memory slave and stream sink: samples handshakes at the edge, drives 1 time unit later
  initial begin : slave_model
    logic ar_f, r_f, ax_f, ax_l, hold_ar, rst_s, rv_hold;
    logic [31:0] ar_a;
    logic [63:0] ax_d;
    bus.m_axi_arready = 1'b0;
    bus.m_axi_rvalid  = 1'b0;
    bus.m_axi_rdata   = 64'd0;
    bus.m_axi_rresp   = 2'b00;
    bus.m_axi_rlast   = 1'b0;
    bus.m_axis_tready = 1'b0;
    forever begin
      @(posedge clk);
      ar_f    = bus.m_axi_arvalid && bus.m_axi_arready;
      hold_ar = bus.m_axi_arvalid && !bus.m_axi_arready;
      ar_a    = bus.m_axi_araddr;
      r_f     = bus.m_axi_rvalid && bus.m_axi_rready;
      ax_f    = bus.m_axis_tvalid && bus.m_axis_tready;
      ax_d    = bus.m_axis_tdata;
      ax_l    = bus.m_axis_tlast;
      rst_s   = !rstn;
      if (ar_f) begin
        last_arlen   = bus.m_axi_arlen;
        last_arsize  = bus.m_axi_arsize;
        last_arburst = bus.m_axi_arburst;
      end
      #1;
      cyc++;
      if (rst_s) begin
        ar_q.delete();
        cur_beat = 0;
        slv_out  = 0;
        bus.m_axi_arready = 1'b0;
        bus.m_axi_rvalid  = 1'b0;
        bus.m_axi_rlast   = 1'b0;
        bus.m_axi_rresp   = 2'b00;
        bus.m_axis_tready = 1'b0;
      end else begin
        if (hold_ar && (!bus.m_axi_arvalid || bus.m_axi_araddr !== ar_a)) stab_err++;
        if (ar_f) begin
          ar_q.push_back(ar_a);
          ar_log.push_back(ar_a);
          slv_out++;
          if (slv_out > max_out) max_out = slv_out;
        end
        if (r_f) begin
          r_count++;
          cur_beat++;
          if (cur_beat == BL) begin
            cur_beat = 0;
            void'(ar_q.pop_front());
            slv_out--;
          end
        end
        if (ax_f) begin
          if (ax_l) begin
            tlast_cnt++;
            tlast_idx = rx_q.size();
          end
          rx_q.push_back(ax_d);
        end
        bus.m_axi_arready = (rgap != 0) ? ($urandom_range(0, 1) == 1) : 1'b1;
        rv_hold = bus.m_axi_rvalid && !r_f;
        if (!rv_hold) begin
          if (ar_q.size() > 0 && !(rgap != 0 && $urandom_range(0, 2) == 0)) begin
            bus.m_axi_rvalid = 1'b1;
            bus.m_axi_rdata  = word_at(ar_q[0] + 32'(cur_beat * 8));
            bus.m_axi_rresp  = (r_count == fault_resp) ? 2'b10 : 2'b00;
            if (fault_last >= 0 && (r_count / BL) == (fault_last / BL))
              bus.m_axi_rlast = (cur_beat == fault_last % BL);
            else
              bus.m_axi_rlast = (cur_beat == BL - 1);
          end else begin
            bus.m_axi_rvalid = 1'b0;
            bus.m_axi_rlast  = 1'b0;
          end
        end
        bus.m_axis_tready = (tr_mode == 1) ? ((cyc % 3) != 0) : 1'b1;
      end
    end
  end

  task automatic start_run(input int id, input logic [31:0] b, input logic [15:0] n);
    rx_q.delete();
    ar_log.delete();
    tlast_cnt = 0;
    tlast_idx = -1;
    r_count   = 0;
    max_out   = 0;
    stab_err  = 0;
    @(negedge clk);
    start = 1'b1;
    base_addr = b;
    n_bursts = n;
    @(negedge clk);
    start = 1'b0;
    base_addr = 32'hDEAD_BEEF;
    n_bursts = 16'hFFFF;
    check($sformatf("t%0d_busy_n1", id), 64'(busy), 64'd1);
    check($sformatf("t%0d_arvalid_n1", id), 64'(bus.m_axi_arvalid), 64'(n != 16'd0));
    check($sformatf("t%0d_err_cleared", id), 64'(err), 64'd0);
  endtask

  task automatic wait_done(input int id);
    int guard = 0;
    while (done !== 1'b1 && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    check($sformatf("t%0d_done_seen", id), 64'(done), 64'd1);
  endtask

  task automatic check_stream(input int id, input logic [31:0] addr0, input int beats);
    int bad = 0;
    for (int i = 0; i < rx_q.size(); i++)
      if (rx_q[i] !== word_at(addr0 + 32'(i * 8))) bad++;
    check($sformatf("t%0d_beats", id), 64'(rx_q.size()), 64'(beats));
    check($sformatf("t%0d_data_bad", id), 64'(bad), 64'd0);
    check($sformatf("t%0d_tlast_cnt", id), 64'(tlast_cnt), 64'd1);
    check($sformatf("t%0d_tlast_idx", id), 64'(tlast_idx), 64'(beats - 1));
  endtask

  task automatic err_probe(input string nm, input int idx);
    int guard = 0;
    logic pre = 1'bx;
    while (r_count <= idx && guard < 1000) begin
      if (r_count == idx) pre = err;
      @(negedge clk);
      guard++;
    end
    check({nm, "_err_before"}, 64'(pre), 64'd0);
    check({nm, "_err_after"}, 64'(err), 64'd1);
  endtask

  task automatic run_vec(input int id, input vec_t v);
    int bad = 0;
    tr_mode = v.tr_mode;
    rgap    = v.rgap;
    start_run(id, v.base, v.nb);
    wait_done(id);
    if (v.exp_cycles >= 0) check($sformatf("t%0d_cycles", id), 64'(cycles), 64'(v.exp_cycles));
    check($sformatf("t%0d_err", id), 64'(err), 64'd0);
    @(negedge clk);
    check($sformatf("t%0d_busy_done_after", id), 64'({busy, done}), 64'd0);
    check_stream(id, v.addr0, v.beats);
    for (int k = 0; k < ar_log.size(); k++)
      if (ar_log[k] !== v.addr0 + 32'(k * BL * 8)) bad++;
    check($sformatf("t%0d_ar_count", id), 64'(ar_log.size()), 64'(v.nb));
    check($sformatf("t%0d_ar_addr_bad", id), 64'(bad), 64'd0);
    check($sformatf("t%0d_ar_attr", id), 64'({last_arlen, last_arsize, last_arburst}),
          64'({8'd15, 3'd3, 2'b01}));
    check($sformatf("t%0d_max_outstanding_ok", id), 64'(max_out <= 2), 64'd1);
    check($sformatf("t%0d_araddr_stable", id), 64'(stab_err), 64'd0);
  endtask

  initial begin : main
    vec_t rv;
    vecs[0] = '{32'h1000_0000, 16'd4, 0, 0, 32'h1000_0000, 64, 66};
    vecs[1] = '{32'h1000_0000, 16'd4, 1, 1, 32'h1000_0000, 64, -1};
    vecs[2] = '{32'h1000_0045, 16'd1, 0, 0, 32'h1000_0000, 16, 18};
    vecs[3] = '{32'h2000_0F80, 16'd2, 0, 0, 32'h2000_0F80, 32, 34};

    rstn = 1'b0;
    start = 1'b0;
    base_addr = 32'd0;
    n_bursts = 16'd0;
    repeat (3) @(negedge clk);
    check("reset_ctrl", 64'({busy, done, err, bus.m_axi_arvalid, bus.m_axi_rready,
                             bus.m_axis_tvalid, bus.m_axis_tlast}), 64'd0);
    check("reset_cycles", 64'(cycles), 64'd0);
    check("reset_araddr", 64'(bus.m_axi_araddr), 64'd0);
    rstn = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 4; i++) run_vec(i, vecs[i]);

    // Response error on beat 5: flagged, sticky, data untouched
    tr_mode = 0;
    rgap = 0;
    fault_resp = 5;
    start_run(10, 32'h1000_0000, 16'd4);
    err_probe("rresp", 5);
    wait_done(10);
    check("t10_err_sticky", 64'(err), 64'd1);
    check_stream(10, 32'h1000_0000, 64);
    fault_resp = -1;

    // rlast moved to beat 14 of burst 1; err must be cleared by this start
    fault_last = BL + 14;
    start_run(11, 32'h1000_0000, 16'd4);
    err_probe("rlast", BL + 14);
    wait_done(11);
    check_stream(11, 32'h1000_0000, 64);
    fault_last = -1;
    @(negedge clk);

    // Zero-length run: done at N+2, no AR, cycles cleared
    start_run(12, 32'h1000_0000, 16'd0);
    check("t12_done_n1", 64'(done), 64'd0);
    @(negedge clk);
    check("t12_done_n2", 64'({done, busy}), 64'b11);
    @(negedge clk);
    check("t12_after", 64'({done, busy}), 64'd0);
    check("t12_cycles", 64'(cycles), 64'd0);
    check("t12_no_ar", 64'(ar_log.size()), 64'd0);

    // Reset while burst 2 is in flight, then a clean restart
    start_run(13, 32'h3000_0000, 16'd4);
    for (int g = 0; g < 500 && ar_log.size() < 3; g++) @(negedge clk);
    check("t13_reached_burst2", 64'(ar_log.size() >= 3), 64'd1);
    rstn = 1'b0;
    @(negedge clk);
    check("t13_reset_ctrl", 64'({busy, done, err, bus.m_axi_arvalid, bus.m_axi_rready,
                                bus.m_axis_tvalid, bus.m_axis_tlast}), 64'd0);
    check("t13_reset_cycles", 64'(cycles), 64'd0);
    check("t13_reset_araddr", 64'(bus.m_axi_araddr), 64'd0);
    rstn = 1'b1;
    @(negedge clk);
    rv = '{32'h3000_0000, 16'd2, 0, 0, 32'h3000_0000, 32, 34};
    run_vec(14, rv);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
